// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle processor: ALU ops, opcodes,
// datapath select encodings and the control FSM state type.
package cpu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_SHR  = 3'd2;
    localparam logic [2:0] ALU_SHL  = 3'd3;
    localparam logic [2:0] ALU_NAND = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_DIR  = 3'd6;
    localparam logic [2:0] ALU_SAR  = 3'd7;

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam logic       SRC_A_PC  = 1'b0;
    localparam logic       SRC_A_REG = 1'b1;

    localparam logic [1:0] SRC_B_REG = 2'd0;
    localparam logic [1:0] SRC_B_ONE = 2'd1;
    localparam logic [1:0] SRC_B_IMM = 2'd2;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP
    } state_e;

    function automatic logic is_rtype(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback and
// drives every ALU and datapath enable; counts retired instructions.
module ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned RET_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             z,
    input  logic             mem_ready,
    output logic [2:0]       alu_op,
    output logic             src_a,
    output logic [1:0]       src_b,
    output logic [1:0]       pc_src,
    output logic             pc_write,
    output logic             ir_write,
    output logic             aluout_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic [RET_W-1:0] ret_cnt
);

    state_e           state_q, state_d;
    logic [RET_W-1:0] ret_cnt_q, ret_cnt_d;

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        ret_cnt_q <= ret_cnt_d;
    end

    assign ret_cnt = ret_cnt_q;

    always_comb begin
        state_d   = state_q;
        ret_cnt_d = ret_cnt_q + RET_W'(instr_done);
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_rtype(opcode)) begin
                    state_d = S_EXEC_R;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW:   state_d = S_ADDR;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_JMP:         state_d = S_JUMP;
                        default:        state_d = S_FETCH;
                    endcase
                end
            end
            S_EXEC_R: state_d = S_WB_R;
            S_ADDR:   state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: if (mem_ready) state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        if (rst) begin
            state_d   = S_FETCH;
            ret_cnt_d = '0;
        end
    end

    // While rst is high every output holds its idle value, so an aborted
    // instruction can neither write back nor retire.
    always_comb begin
        alu_op       = ALU_ADD;
        src_a        = SRC_A_PC;
        src_b        = SRC_B_REG;
        pc_src       = PC_SRC_ALU;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        aluout_write = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        instr_done   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    src_b    = SRC_B_ONE;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    src_b        = SRC_B_IMM;
                    aluout_write = 1'b1;
                    instr_done   = ~is_rtype(opcode) && (opcode > OP_JMP);
                end
                S_EXEC_R: begin
                    alu_op       = opcode[2:0];
                    src_a        = SRC_A_REG;
                    aluout_write = 1'b1;
                end
                S_WB_R: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDR: begin
                    src_a        = SRC_A_REG;
                    src_b        = SRC_B_IMM;
                    aluout_write = 1'b1;
                end
                S_MEM_RD: mem_read = 1'b1;
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
                S_BRANCH: begin
                    alu_op     = ALU_SUB;
                    src_a      = SRC_A_REG;
                    pc_src     = PC_SRC_ALUOUT;
                    pc_write   = z ^ opcode[0];
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = PC_SRC_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed, table-driven check of ctrl_fsm: each row is one clock cycle of
// inputs with the hand-computed outputs expected in that cycle.
module tb_ctrl_fsm;

    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    opcode;
    logic          z;
    logic          mem_ready;
    logic [2:0]    alu_op;
    logic          src_a;
    logic [1:0]    src_b;
    logic [1:0]    pc_src;
    logic          pc_write, ir_write, aluout_write, mem_read, mem_write;
    logic          reg_write, mem_to_reg, instr_done;
    logic [RW-1:0] ret_cnt;

    ctrl_fsm #(.RET_W(RW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .z(z), .mem_ready(mem_ready),
        .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .pc_src(pc_src),
        .pc_write(pc_write), .ir_write(ir_write), .aluout_write(aluout_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    // en = {pc_write, ir_write, aluout_write, mem_read, mem_write, reg_write, mem_to_reg, instr_done}
    typedef struct {
        logic          rst;
        logic [3:0]    op;
        logic          z;
        logic          rdy;
        logic [2:0]    alu;
        logic          sa;
        logic [1:0]    sb;
        logic [1:0]    ps;
        logic [7:0]    en;
        logic [RW-1:0] ret;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [7:0] E_FETCH  = 8'b1101_0000;
    localparam logic [7:0] E_FWAIT  = 8'b0001_0000;
    localparam logic [7:0] E_AOUT   = 8'b0010_0000;
    localparam logic [7:0] E_WBR    = 8'b0000_0101;
    localparam logic [7:0] E_WBM    = 8'b0000_0111;
    localparam logic [7:0] E_ILL    = 8'b0010_0001;
    localparam logic [7:0] E_BTAKEN = 8'b1000_0001;
    localparam logic [7:0] E_BNOT   = 8'b0000_0001;
    localparam logic [7:0] E_MWWAIT = 8'b0000_1000;
    localparam logic [7:0] E_MWDONE = 8'b0000_1001;

    task automatic push(input logic r, input logic [3:0] op, input logic zz, input logic rdy,
                        input logic [2:0] alu, input logic sa, input logic [1:0] sb,
                        input logic [1:0] ps, input logic [7:0] en, input int ret);
        vec_t v;
        v.rst = r; v.op = op; v.z = zz; v.rdy = rdy;
        v.alu = alu; v.sa = sa; v.sb = sb; v.ps = ps; v.en = en; v.ret = RW'(ret);
        vq.push_back(v);
    endtask

    task automatic push_rtype(input logic [3:0] op, input int ret);
        push(0, op, 0, 1, 3'd0, 0, 2'd1, 2'd0, E_FETCH, ret);
        push(0, op, 1, 1, 3'd0, 0, 2'd2, 2'd0, E_AOUT, ret);
        push(0, op, 0, 1, op[2:0], 1, 2'd0, 2'd0, E_AOUT, ret);
        push(0, op, 1, 1, 3'd0, 0, 2'd0, 2'd0, E_WBR, ret);
    endtask

    task automatic push_branch(input logic [3:0] op, input logic zz, input logic [7:0] en, input int ret);
        push(0, op, 0, 1, 3'd0, 0, 2'd1, 2'd0, E_FETCH, ret);
        push(0, op, ~zz, 1, 3'd0, 0, 2'd2, 2'd0, E_AOUT, ret);
        push(0, op, zz, 1, 3'd1, 1, 2'd0, 2'd1, en, ret);
    endtask

    task automatic chk(input int idx, input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL row %0d %s: got %0d expected %0d", idx, name, act, exp);
        end
    endtask

    initial begin
        // Reset cycle and R-type sequences
        push(1, 4'h0, 0, 1, 3'd0, 0, 2'd0, 2'd0, 8'h00, 0);
        push_rtype(4'b0000, 0);
        push_rtype(4'b0111, 1);
        push_rtype(4'b0100, 2);
        // LW with one fetch wait and three MEM_RD waits
        push(0, 4'h8, 0, 0, 3'd0, 0, 2'd1, 2'd0, E_FWAIT, 3);
        push(0, 4'h8, 0, 1, 3'd0, 0, 2'd1, 2'd0, E_FETCH, 3);
        push(0, 4'h8, 0, 1, 3'd0, 0, 2'd2, 2'd0, E_AOUT, 3);
        push(0, 4'h8, 0, 1, 3'd0, 1, 2'd2, 2'd0, E_AOUT, 3);
        for (int i = 0; i < 3; i++)
            push(0, 4'h8, 0, 0, 3'd0, 0, 2'd0, 2'd0, E_FWAIT, 3);
        push(0, 4'h8, 0, 1, 3'd0, 0, 2'd0, 2'd0, E_FWAIT, 3);
        push(0, 4'h8, 0, 1, 3'd0, 0, 2'd0, 2'd0, E_WBM, 3);
        // Branches, jump, illegal
        push_branch(4'hA, 1, E_BTAKEN, 4);
        push_branch(4'hA, 0, E_BNOT, 5);
        push_branch(4'hB, 1, E_BNOT, 6);
        push_branch(4'hB, 0, E_BTAKEN, 7);
        push(0, 4'hC, 0, 1, 3'd0, 0, 2'd1, 2'd0, E_FETCH, 8);
        push(0, 4'hC, 0, 1, 3'd0, 0, 2'd2, 2'd0, E_AOUT, 8);
        push(0, 4'hC, 1, 1, 3'd0, 0, 2'd0, 2'd2, E_BTAKEN, 8);
        push(0, 4'hE, 0, 1, 3'd0, 0, 2'd1, 2'd0, E_FETCH, 9);
        push(0, 4'hE, 0, 1, 3'd0, 0, 2'd2, 2'd0, E_ILL, 9);
        // SW with one write wait
        push(0, 4'h9, 0, 1, 3'd0, 0, 2'd1, 2'd0, E_FETCH, 10);
        push(0, 4'h9, 0, 1, 3'd0, 0, 2'd2, 2'd0, E_AOUT, 10);
        push(0, 4'h9, 0, 1, 3'd0, 1, 2'd2, 2'd0, E_AOUT, 10);
        push(0, 4'h9, 0, 0, 3'd0, 0, 2'd0, 2'd0, E_MWWAIT, 10);
        push(0, 4'h9, 0, 1, 3'd0, 0, 2'd0, 2'd0, E_MWDONE, 10);
        // SW aborted by rst in MEM_WR: no retire, counter cleared, fetch follows
        push(0, 4'h9, 0, 1, 3'd0, 0, 2'd1, 2'd0, E_FETCH, 11);
        push(0, 4'h9, 0, 1, 3'd0, 0, 2'd2, 2'd0, E_AOUT, 11);
        push(0, 4'h9, 0, 1, 3'd0, 1, 2'd2, 2'd0, E_AOUT, 11);
        push(0, 4'h9, 0, 0, 3'd0, 0, 2'd0, 2'd0, E_MWWAIT, 11);
        push(1, 4'h9, 0, 1, 3'd0, 0, 2'd0, 2'd0, 8'h00, 11);
        // Counter wrap: 16 illegal NOPs bring a 4-bit count back to 0
        for (int i = 0; i < 16; i++) begin
            push(0, 4'hF, 0, 1, 3'd0, 0, 2'd1, 2'd0, E_FETCH, i);
            push(0, 4'hF, 0, 1, 3'd0, 0, 2'd2, 2'd0, E_ILL, i);
        end
        push_rtype(4'b0101, 0);
        push(0, 4'h0, 0, 0, 3'd0, 0, 2'd1, 2'd0, E_FWAIT, 1);

        rst = 1'b1; opcode = '0; z = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; opcode = vq[i].op; z = vq[i].z; mem_ready = vq[i].rdy;
            #1;
            chk(i, "alu_op", int'(alu_op), int'(vq[i].alu));
            chk(i, "src_a", int'(src_a), int'(vq[i].sa));
            chk(i, "src_b", int'(src_b), int'(vq[i].sb));
            chk(i, "pc_src", int'(pc_src), int'(vq[i].ps));
            chk(i, "enables", int'({pc_write, ir_write, aluout_write, mem_read,
                                     mem_write, reg_write, mem_to_reg, instr_done}),
                int'(vq[i].en));
            chk(i, "ret_cnt", int'(ret_cnt), int'(vq[i].ret));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
